// File: rtl/wave_pwm_dac.sv
// wave_pwm_dac: gain/offset scaling with saturation, feeding a 256-step PWM
// whose duty only changes at a period boundary.
module wave_pwm_dac #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [7:0]            sample_in,
  input  logic [7:0]            gain,
  input  logic [7:0]            offset,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  clr_sat,
  output logic                  pwm_out,
  output logic                  period_start,
  output logic [7:0]            duty_applied,
  output logic                  sat_hi,
  output logic                  sat_lo
);
  logic [7:0] scaled, pending_duty, clamped, phase, phase_next, duty_next;
  logic [9:0] sum;
  logic [PRESCALE_W-1:0] pcnt;
  logic over, under, tick, wrap;
  always_comb begin
    sum = 10'(scaled) + {{2{offset[7]}}, offset};
    under = sum[9];
    over = !sum[9] && sum[8];
    clamped = under ? 8'd0 : over ? 8'hFF : sum[7:0];
    tick = enable && (pcnt >= prescale);
    phase_next = phase + 8'd1;
    wrap = tick && (phase == 8'hFF);
    duty_next = wrap ? pending_duty : duty_applied;
  end
  // (gain+1)/256 scaling cannot exceed 255, so the top byte of the 16-bit product is exact
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scaled <= '0;
      pending_duty <= '0;
      sat_hi <= 1'b0;
      sat_lo <= 1'b0;
    end else begin
      scaled <= 8'((17'(sample_in) * (17'(gain) + 17'd1)) >> 8);
      pending_duty <= clamped;
      sat_hi <= over | (sat_hi & ~clr_sat);
      sat_lo <= under | (sat_lo & ~clr_sat);
    end
  end
  // Disable parks the PWM so the first tick after re-enable wraps into a fresh period
  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      pcnt <= '0;
      phase <= 8'hFF;
      pwm_out <= 1'b0;
      duty_applied <= '0;
      period_start <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      period_start <= wrap;
      if (tick) begin
        phase <= phase_next;
        duty_applied <= duty_next;
        pwm_out <= phase_next < duty_next;
      end
    end
  end
endmodule

// File: tb/tb_wave_pwm_dac.sv
// tb_wave_pwm_dac: directed checks of scaling, saturation, period-aligned duty and enable/reset.
module tb_wave_pwm_dac;
  logic clk = 0, rst_n = 0, enable = 1, clr_sat = 0;
  logic [7:0] sample_in = 200, gain = 255, offset = 0;
  logic [15:0] prescale = 0;
  logic pwm_out, period_start, sat_hi, sat_lo;
  logic [7:0] duty_applied;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  wave_pwm_dac #(.PRESCALE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in), .gain(gain),
    .offset(offset), .prescale(prescale), .clr_sat(clr_sat), .pwm_out(pwm_out),
    .period_start(period_start), .duty_applied(duty_applied), .sat_hi(sat_hi), .sat_lo(sat_lo)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  // Starts at a period_start cycle, ends at the next one; optionally changes sample_in mid-period
  task automatic meas(input string tag, input int exp_len, input int exp_high, input int exp_duty,
                      input int chg_at = -1, input logic [7:0] chg_val = 0);
    int l = 0, h = 0;
    logic [7:0] d;
    d = duty_applied;
    check({tag, "_ps"}, period_start, 1);
    do begin
      h += int'(pwm_out);
      l++;
      if (l == chg_at) sample_in = chg_val;
      @(negedge clk);
    end while (!period_start && l < 4000);
    check({tag, "_len"}, l, exp_len);
    check({tag, "_high"}, h, exp_high);
    check({tag, "_duty"}, d, exp_duty);
  endtask
  task automatic sync();
    int l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!period_start && l < 4000);
    if (!period_start) check("sync_timeout", 0, 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_pwm", pwm_out, 0);
    check("rst_ps", period_start, 0);
    check("rst_duty", duty_applied, 0);
    check("rst_sat_hi", sat_hi, 0);
    check("rst_sat_lo", sat_lo, 0);
    rst_n = 1;
    @(negedge clk);
    check("first_ps", period_start, 1);
    meas("p0", 256, 0, 0);
    meas("p200", 256, 200, 200);
    sample_in = 255; gain = 127; offset = 10;
    meas("p200b", 256, 200, 200);
    meas("p137", 256, 137, 137);
    sample_in = 250; gain = 255; offset = 20;
    meas("p137b", 256, 137, 137);
    meas("p255", 256, 255, 255);
    check("sat_hi_set", sat_hi, 1);
    check("sat_lo_clear", sat_lo, 0);
    sample_in = 5; offset = 8'hEC;
    meas("p255b", 256, 255, 255);
    meas("plo", 256, 0, 0);
    check("sat_lo_set", sat_lo, 1);
    check("sat_hi_sticky", sat_hi, 1);
    clr_sat = 1;
    @(negedge clk);
    clr_sat = 0;
    check("clr_alone_hi", sat_hi, 0);
    check("clr_with_set_lo", sat_lo, 1);
    offset = 0;
    repeat (3) @(negedge clk);
    clr_sat = 1;
    @(negedge clk);
    clr_sat = 0;
    check("clr_alone_lo", sat_lo, 0);
    sample_in = 250; offset = 20;
    repeat (3) @(negedge clk);
    check("resat_hi", sat_hi, 1);
    clr_sat = 1;
    @(negedge clk);
    clr_sat = 0;
    check("clr_with_set_hi", sat_hi, 1);
    sync();
    prescale = 3; sample_in = 50; offset = 0;
    sync();
    meas("pres50", 1024, 200, 50, 500, 180);
    meas("pres180", 1024, 720, 180);
    prescale = 2;
    repeat (100) @(negedge clk);
    enable = 0;
    @(negedge clk);
    check("dis_pwm", pwm_out, 0);
    check("dis_duty", duty_applied, 0);
    check("dis_ps", period_start, 0);
    repeat (9) @(negedge clk);
    enable = 1;
    @(negedge clk);
    check("reen_ps1", period_start, 0);
    @(negedge clk);
    check("reen_ps2", period_start, 0);
    @(negedge clk);
    check("reen_duty", duty_applied, 180);
    check("reen_pwm", pwm_out, 1);
    meas("reen", 768, 540, 180);
    repeat (50) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    check("mid_rst_pwm", pwm_out, 0);
    check("mid_rst_duty", duty_applied, 0);
    check("mid_rst_sat_hi", sat_hi, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wave_pwm_dac.md
# wave_pwm_dac

Output stage placed directly downstream of the function generator. It takes the generator's 8-bit `signal_waveform` sample stream and applies amplitude gain and signed offset with saturation. It converts the result into a 1-bit, 256-step PWM that drives the board's RC-filtered audio/analog pin. A new duty value is only ever applied at a PWM period boundary, so the pin never shows a torn period.

## Interface
Parameters:
- `PRESCALE_W`, default 16: width of the PWM tick prescaler.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `enable`  in  1  level; 1 = PWM running; 0 = output parked low.
- `sample_in`  in  8  unsigned sample from the function generator; sampled every clock.
- `gain`  in  8  amplitude scale, unsigned; effective factor is (gain+1)/256, so 255 = unity.
- `offset`  in  8  two's-complement offset (-128..127) added after gain.
- `prescale`  in  PRESCALE_W  PWM tick every prescale+1 clocks.
- `clr_sat`  in  1  clears the sticky saturation flags.
- `pwm_out`  out  1  PWM pin, registered.
- `period_start`  out  1  one-cycle pulse in the cycle the phase wraps to 0.
- `duty_applied`  out  8  duty currently driving the pin.
- `sat_hi`  out  1  sticky; an offset add clamped to 255.
- `sat_lo`  out  1  sticky; an offset add clamped to 0.

## Operation
- Stage 1, registered: `prod = sample_in * (gain+1)` as a 17-bit product; `scaled = prod[15:8]`. The maximum is 255*256>>8 = 255, so no overflow is possible.
- Stage 2, registered: `sum = {1'b0,scaled} + sign-extended offset` in 10-bit signed arithmetic.
  - sum > 255 gives `pending_duty` = 255 and sets `sat_hi`.
  - sum < 0 gives `pending_duty` = 0 and sets `sat_lo`.
  - Otherwise `pending_duty` = sum[7:0].
- Stages 1 and 2 run every cycle regardless of `enable`.
- Prescaler `pcnt`:
  - `tick` = enable && (pcnt >= prescale).
  - On tick, pcnt <= 0; otherwise pcnt increments while enabled.
  - The `>=` compare makes a mid-count reduction of `prescale` tick on the next cycle rather than wrapping through 2^PRESCALE_W.
- Phase counter `phase`, 8 bits, advances by 1 on each tick and wraps 255 -> 0.
- When a tick wraps `phase` to 0:
  - `duty_applied` <= `pending_duty`.
  - `period_start` pulses for one cycle.
- `pwm_out` <= (phase_next < duty_next), evaluated on every tick and held between ticks.
  - Duty 0 gives a constant low output.
  - Duty 255 gives high for 255 of 256 phases.
- `enable` = 0, synchronous, with priority over tick:
  - pcnt <= 0, phase <= 8'hFF, `pwm_out` <= 0, `duty_applied` <= 0, `period_start` <= 0.
  - Re-enabling therefore starts a fresh period on the first tick.
- Sticky flags: a set in the same cycle as `clr_sat` wins, so the flag stays 1.

## Timing
- Reset values: `pwm_out` 0, `period_start` 0, `duty_applied` 0, `sat_hi` 0, `sat_lo` 0, pcnt 0, phase 8'hFF, pipeline registers 0.
- `sample_in` to `pending_duty`: 2 clocks.
- `pending_duty` to pin: applied at the next phase wrap, i.e. at most 256*(prescale+1) clocks later.
- First tick after `enable` rises: cycle prescale+1 after the first enabled cycle, counted from pcnt = 0. With prescale = 0, the tick happens in the first enabled cycle.
- Output registers relative to the tick cycle:
  - `period_start`, `duty_applied` and `pwm_out` update on the clock edge ending the tick cycle.
  - `period_start` is high for exactly the following cycle.
- PWM period = 256*(prescale+1) clocks.
- High time = duty_applied*(prescale+1) clocks.
- `gain`, `offset` and `prescale` changes take effect without a glitch:
  - `gain` and `offset` through the pipeline, then the next wrap.
  - `prescale` on the next compare.
- Reset asserted mid-period forces every reset value on the next edge; there is no partial-period completion.

## Test plan
- Reset with `enable` = 1, prescale = 0 -> all outputs 0 in the reset cycle; first `period_start` in the first cycle after release.
- sample_in = 200, gain = 255, offset = 0, prescale = 0 -> `duty_applied` = 200 at the next wrap; `pwm_out` high exactly 200 of every 256 clocks; `period_start` every 256 clocks.
- sample_in = 255, gain = 127, offset = +10 -> `duty_applied` = 137.
  - sample_in = 250, gain = 255, offset = +20 -> duty 255, `sat_hi` = 1.
  - sample_in = 5, offset = -20 -> duty 0, `pwm_out` constantly 0, `sat_lo` = 1.
- `clr_sat` pulsed in the same cycle as a new clamp -> flag stays 1; `clr_sat` pulsed alone -> flag 0 the next cycle.
- sample_in changed from 50 to 180 mid-period (prescale = 3) -> the current period keeps 50*4 high clocks; the next period shows 180*4; `period_start` spacing is 1024 clocks.
- `enable` dropped mid-period, then raised 10 clocks later with prescale = 2 -> `pwm_out` and `duty_applied` are 0 the cycle after the drop; first tick and `period_start` arrive 3 clocks after re-enable.
